usb_rx_field_sr: RTL and testbench

- Parametrised receive-side field shift register for the USB packet receiver.
- Deserialises LSB-first NRZI-decoded, de-stuffed bits into a field whose length is selected per field: PID = 8, address+endp = 11, CRC16 = 16, data byte = 8.
- Counts accepted bits and presents the field right-justified in a holding register with a one-cycle valid strobe.
- Optional PID check-nibble verification; abort on EOP or error.
- Sits between the bit-stuff remover and the receive control FSM, replacing the fixed 8-bit PID shift register.

---
 rtl/usb_rx_field_sr.sv | 151 +++++++++++++++
 tb/tb_usb_rx_field_sr.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_field_sr.sv
// rtl/usb_rx_field_sr.sv - receive-side variable-length field shift register for the USB packet receiver
//
// Purpose:
//   Collects LSB-first, NRZI-decoded, de-stuffed bits into a field of
//   1..WIDTH bits. The field length is chosen when the capture starts.
//   The completed field is presented right-justified in a holding register,
//   together with a one-cycle valid strobe. An optional PID check-nibble test
//   runs on 8-bit fields.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   in_data      in   decoded serial bit
//   data_shift   in   bit strobe, one pulse per bit period
//   read_val     in   1 = real data bit, 0 = stuffed bit (ignored)
//   start        in   pulse: clear and begin capturing a new field
//   field_len    in   field length in bits, sampled on start (0 or >WIDTH means WIDTH)
//   pid_mode     in   enable the PID check for this field, sampled on start
//   abort        in   EOP/error: discard the field in progress
//   field_data   out  last completed field, right-justified, zero-extended
//   field_valid  out  one-cycle pulse when field_data/pid_err are updated
//   pid_err      out  PID check failed for the last completed field
//   busy         out  capture in progress
//   bit_cnt      out  bits accepted so far in the current field

module usb_rx_field_sr #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_data,
   input  logic             data_shift,
   input  logic             read_val,
   input  logic             start,
   input  logic [CNT_W-1:0] field_len,
   input  logic             pid_mode,
   input  logic             abort,
   output logic [WIDTH-1:0] field_data,
   output logic             field_valid,
   output logic             pid_err,
   output logic             busy,
   output logic [CNT_W-1:0] bit_cnt
);

   localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] PID_LEN = CNT_W'(8);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic             pid_q, pid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;

   logic             accept;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] result;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] len_eff;

   assign accept  = data_shift & read_val;
   // New bits enter at the MSB, so the first bit received drifts down to
   // bit (WIDTH-len) and the final right-shift moves it to bit 0.
   assign shifted = {in_data, shift_q[WIDTH-1:1]};
   assign result  = shifted >> (WIDTH_C - len_q);
   assign cnt_inc = cnt_q + 1'b1;
   assign len_eff = ((field_len == '0) || (field_len > WIDTH_C)) ? WIDTH_C : field_len;

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      pid_d   = pid_q;
      data_d  = data_q;
      valid_d = 1'b0;
      err_d   = err_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               shift_d = '0;
               cnt_d   = '0;
               len_d   = len_eff;
               pid_d   = pid_mode;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (abort) begin
               // Holding register and pid_err keep the last completed field.
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (start) begin
               // Restart wins over any bit on the same edge, including a final bit.
               shift_d = '0;
               cnt_d   = '0;
               len_d   = len_eff;
               pid_d   = pid_mode;
            end else if (accept) begin
               shift_d = shifted;
               cnt_d   = cnt_inc;
               if (cnt_inc == len_q) begin
                  data_d  = result;
                  err_d   = pid_q && (len_q == PID_LEN) && (result[7:4] != ~result[3:0]);
                  valid_d = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         pid_q   <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         pid_q   <= pid_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign field_data  = data_q;
   assign field_valid = valid_q;
   assign pid_err     = err_q;
   assign busy        = (state_q == ST_SHIFT);
   assign bit_cnt     = cnt_q;

endmodule

// File: tb/tb_usb_rx_field_sr.sv
// tb/tb_usb_rx_field_sr.sv - self-checking bench for usb_rx_field_sr

module tb_usb_rx_field_sr;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_data = 1'b0;
   logic        data_shift = 1'b0;
   logic        read_val = 1'b0;
   logic        start = 1'b0;
   logic [4:0]  field_len = '0;
   logic        pid_mode = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] field_data;
   logic        field_valid;
   logic        pid_err;
   logic        busy;
   logic [4:0]  bit_cnt;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: the field is kept as a list of received bits, and its
   // value is computed arithmetically at completion.
   bit m_busy  = 0;
   int m_len   = 0;
   bit m_pid   = 0;
   int m_cnt   = 0;
   int m_data  = 0;
   bit m_err   = 0;
   bit m_valid = 0;
   int m_bits[$];

   usb_rx_field_sr #(.WIDTH(16), .CNT_W(5)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .data_shift  (data_shift),
      .read_val    (read_val),
      .start       (start),
      .field_len   (field_len),
      .pid_mode    (pid_mode),
      .abort       (abort),
      .field_data  (field_data),
      .field_valid (field_valid),
      .pid_err     (pid_err),
      .busy        (busy),
      .bit_cnt     (bit_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic check_all(input string tag);
      check({tag, ".field_valid"}, 32'(field_valid), 32'(m_valid));
      check({tag, ".field_data"},  32'(field_data),  32'(m_data));
      check({tag, ".pid_err"},     32'(pid_err),     32'(m_err));
      check({tag, ".busy"},        32'(busy),        32'(m_busy));
      check({tag, ".bit_cnt"},     32'(bit_cnt),     32'(m_cnt));
   endtask

   task automatic model_start(input int len, input bit pm);
      m_len  = (len == 0 || len > 16) ? 16 : len;
      m_pid  = pm;
      m_cnt  = 0;
      m_busy = 1;
      m_bits.delete();
   endtask

   // One clock cycle: apply inputs, take the edge, update the model, compare.
   task automatic cyc(input bit r, input bit st, input int len, input bit pm,
                      input bit ds, input bit rv, input bit b, input bit ab,
                      input string tag);
      int v;
      rst = r; start = st; field_len = 5'(len); pid_mode = pm;
      data_shift = ds; read_val = rv; in_data = b; abort = ab;
      @(posedge clk);
      #1;
      rst = 0; start = 0; data_shift = 0; read_val = 0; in_data = 0; abort = 0;
      m_valid = 0;
      if (r) begin
         m_busy = 0; m_cnt = 0; m_data = 0; m_err = 0; m_len = 0; m_pid = 0;
         m_bits.delete();
      end else if (m_busy) begin
         if (ab) begin
            m_busy = 0;
            m_cnt  = 0;
         end else if (st) begin
            model_start(len, pm);
         end else if (ds && rv) begin
            m_bits.push_back(int'(b));
            m_cnt++;
            if (m_cnt == m_len) begin
               v = 0;
               foreach (m_bits[i]) v += m_bits[i] << i;
               m_data  = v;
               m_err   = m_pid && (m_len == 8) && ((v / 16) != (15 - (v % 16)));
               m_valid = 1;
               m_busy  = 0;
            end
         end
      end else if (st) begin
         model_start(len, pm);
      end
      check_all(tag);
   endtask

   task automatic do_start(input int len, input bit pm, input string tag);
      cyc(0, 1, len, pm, 0, 0, 0, 0, tag);
   endtask

   task automatic send_bits(input int v, input int lo, input int hi, input string tag);
      for (int i = lo; i <= hi; i++)
         cyc(0, 0, 0, 0, 1, 1, bit'((v >> i) & 1), 0, tag);
   endtask

   initial begin
      int r;
      int len;

      cyc(1, 0, 0, 0, 0, 0, 0, 0, "reset");
      check("reset.data0", 32'(field_data), 32'h0);

      do_start(8, 1, "ack.start");
      send_bits(32'hD2, 0, 7, "ack.bit");
      check("ack.data", 32'(field_data), 32'h00D2);
      check("ack.valid", 32'(field_valid), 32'h1);
      check("ack.busy", 32'(busy), 32'h0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, "ack.after");

      do_start(8, 1, "bad.start");
      send_bits(32'hD3, 0, 7, "bad.bit");
      check("bad.pid_err", 32'(pid_err), 32'h1);
      do_start(8, 0, "nopid.start");
      send_bits(32'hD3, 0, 7, "nopid.bit");
      check("nopid.pid_err", 32'(pid_err), 32'h0);

      do_start(11, 0, "tok.start");
      send_bits(32'h5A3, 0, 6, "tok.bit");
      cyc(0, 0, 0, 0, 1, 0, 1, 0, "tok.stuff");
      send_bits(32'h5A3, 7, 10, "tok.bit");
      check("tok.data", 32'(field_data), 32'h05A3);
      check("tok.cnt", 32'(bit_cnt), 32'd11);

      do_start(0, 0, "crc0.start");
      send_bits(32'hBEEF, 0, 15, "crc0.bit");
      check("crc0.data", 32'(field_data), 32'hBEEF);
      do_start(20, 0, "crc20.start");
      send_bits(32'h1234, 0, 14, "crc20.bit");
      check("crc20.busy15", 32'(busy), 32'h1);
      send_bits(32'h1234, 15, 15, "crc20.bit");
      check("crc20.data", 32'(field_data), 32'h1234);

      do_start(8, 0, "abort.start");
      send_bits(32'hFF, 0, 3, "abort.bit");
      cyc(0, 0, 0, 0, 0, 0, 0, 1, "abort.pulse");
      check("abort.data_kept", 32'(field_data), 32'h1234);
      check("abort.cnt", 32'(bit_cnt), 32'h0);
      do_start(8, 0, "restart.start");
      send_bits(32'h1F, 0, 4, "restart.bit");
      do_start(8, 0, "restart.again");
      send_bits(32'h5A, 0, 7, "restart.bit2");
      check("restart.data", 32'(field_data), 32'h005A);

      do_start(8, 0, "race.start");
      send_bits(32'h3C, 0, 6, "race.bit");
      cyc(0, 1, 8, 0, 1, 1, 1, 0, "race.start_final");
      check("race.novalid", 32'(field_valid), 32'h0);
      send_bits(32'hC3, 0, 7, "race.bit2");
      check("race.data", 32'(field_data), 32'h00C3);

      do_start(8, 0, "rstmid.start");
      send_bits(32'h07, 0, 2, "rstmid.bit");
      cyc(1, 0, 0, 0, 0, 0, 0, 0, "rstmid.rst");
      check("rstmid.data", 32'(field_data), 32'h0);
      send_bits(32'hFF, 0, 3, "rstmid.ignored");
      check("rstmid.cnt", 32'(bit_cnt), 32'h0);

      for (int k = 0; k < 1500; k++) begin
         r = $urandom_range(0, 199);
         len = $urandom_range(0, 20);
         if (r < 1)
            cyc(1, 0, 0, 0, 0, 0, 0, 0, "rnd.rst");
         else if (r < 6 || (!m_busy && r < 60))
            cyc(0, 1, ($urandom_range(0, 3) == 0) ? 8 : len, bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)), 1, bit'($urandom_range(0, 1)), 0, "rnd.start");
         else if (r < 10)
            cyc(0, 0, 0, 0, bit'($urandom_range(0, 1)), 1, 0, 1, "rnd.abort");
         else if (r < 40)
            cyc(0, 0, 0, 0, 0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0, "rnd.idle");
         else if (r < 60)
            cyc(0, 0, 0, 0, 1, 0, bit'($urandom_range(0, 1)), 0, "rnd.stuff");
         else
            cyc(0, 0, 0, 0, 1, 1, bit'($urandom_range(0, 1)), 0, "rnd.bit");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
